// File: rtl/pe_mem_arbiter_if.sv
// PE-side request/acknowledge bundle for pe_mem_arbiter.
// The master modport is the PE cluster; the slave modport is the arbiter.
interface pe_mem_arbiter_if #(
  parameter int NPROC = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  logic [NPROC-1:0]    req;
  logic [NPROC-1:0]    we;
  logic [NPROC*AW-1:0] addr;
  logic [NPROC*DW-1:0] wdata;
  logic [NPROC-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic                busy;

  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NPROC PEs (IDLE -> MEM -> ACK).
// Optional MEMARB_STATS_EN adds a saturating 16-bit stall_cnt output.
module pe_mem_arbiter #(
  parameter int NPROC = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  pe_mem_arbiter_if.slave pe,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
`ifdef MEMARB_STATS_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int PW = (NPROC > 1) ? $clog2(NPROC) : 1;

  typedef enum logic [1:0] {IDLE, MEM, ACK} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    g_q, g_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    idx;
  logic             sel_vld;
  logic [NPROC-1:0] gnt_onehot;

  // Scan backwards from ptr+NPROC-1 so the last hit is the first requester at or after ptr.
  always_comb begin
    sel     = ptr_q;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = NPROC - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NPROC);
      if (pe.req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_onehot      = '0;
    gnt_onehot[g_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        mem_en_d = 1'b0;
        if (sel_vld) begin
          state_d     = MEM;
          g_d         = sel;
          mem_en_d    = 1'b1;
          mem_we_d    = pe.we[sel];
          mem_addr_d  = pe.addr[int'(sel) * AW +: AW];
          mem_wdata_d = pe.wdata[int'(sel) * DW +: DW];
        end
      end
      MEM: begin
        state_d  = ACK;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
      ACK: begin
        state_d = IDLE;
        ptr_d   = (int'(g_q) + 1 >= NPROC) ? '0 : g_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign pe.ack    = (state_q == ACK) ? gnt_onehot : '0;
  assign pe.rdata  = (state_q == ACK) ? mem_rdata : '0;
  assign pe.busy   = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEMARB_STATS_EN
  logic [15:0]      stall_cnt_q;
  logic [NPROC-1:0] gmask;

  // A cycle is a stall when any PE other than the one currently being served is requesting.
  assign gmask = (state_q == IDLE) ? '0 : gnt_onehot;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (((pe.req & ~gmask) != '0) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Scoreboard bench for pe_mem_arbiter: a 2-PE instance for load/store/contention/reset
// and a 4-PE instance for pointer wrap; acks are checked by decoupled negedge monitors.
module tb_pe_mem_arbiter;

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cycNum = 0;
  int          vecCount = 0;
  int          missCount = 0;
  bit          bypassA = 1'b0;
  exp_t        sbA[$];
  exp_t        sbB[$];
  exp_t        eA;
  exp_t        eB;

  logic        memEnA, memWeA;
  logic [15:0] memAddrA, memWdataA, memRdataA;
  logic        memEnB, memWeB;
  logic [15:0] memAddrB, memWdataB, memRdataB;
  logic [15:0] memA [0:1023];
  logic [15:0] memB [0:1023];
`ifdef MEMARB_STATS_EN
  logic [15:0] stallCntA, stallCntB;
`endif

  pe_mem_arbiter_if #(.NPROC(2), .AW(16), .DW(16)) ifA ();
  pe_mem_arbiter_if #(.NPROC(4), .AW(16), .DW(16)) ifB ();

  pe_mem_arbiter #(.NPROC(2), .AW(16), .DW(16)) dutA (
    .clk(clk), .reset(reset), .pe(ifA),
    .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA),
    .mem_wdata(memWdataA), .mem_rdata(memRdataA)
`ifdef MEMARB_STATS_EN
    , .stall_cnt(stallCntA)
`endif
  );

  pe_mem_arbiter #(.NPROC(4), .AW(16), .DW(16)) dutB (
    .clk(clk), .reset(reset), .pe(ifB),
    .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
    .mem_wdata(memWdataB), .mem_rdata(memRdataB)
`ifdef MEMARB_STATS_EN
    , .stall_cnt(stallCntB)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycNum <= cycNum + 1;

  // Read-first single-port memories: rdata returns the pre-write contents one cycle after mem_en.
  always @(posedge clk) begin
    if (memEnA) begin
      memRdataA <= memA[memAddrA[9:0]];
      if (memWeA) memA[memAddrA[9:0]] <= memWdataA;
    end
    if (memEnB) begin
      memRdataB <= memB[memAddrB[9:0]];
      if (memWeB) memB[memAddrB[9:0]] <= memWdataB;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifA.ack != '0 && !bypassA) begin
      if (sbA.size() == 0) begin
        checkOutput("A unexpected ack", 32'(ifA.ack), 32'd0);
      end else begin
        eA = sbA.pop_front();
        checkOutput("A ack", 32'(ifA.ack), 32'(eA.ack));
        checkOutput("A rdata", 32'(ifA.rdata), 32'(eA.rdata));
        checkOutput("A ack cycle", cycNum, eA.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ifB.ack != '0) begin
      if (sbB.size() == 0) begin
        checkOutput("B unexpected ack", 32'(ifB.ack), 32'd0);
      end else begin
        eB = sbB.pop_front();
        checkOutput("B ack", 32'(ifB.ack), 32'(eB.ack));
        checkOutput("B rdata", 32'(ifB.rdata), 32'(eB.rdata));
        checkOutput("B ack cycle", cycNum, eB.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input int p, input logic isStore, input logic [15:0] a, input logic [15:0] d);
    ifA.we[p]           = isStore;
    ifA.addr[p*16 +: 16]  = a;
    ifA.wdata[p*16 +: 16] = d;
    ifA.req[p]          = 1'b1;
  endtask

  task automatic applyStimulusB(input int p, input logic [15:0] a);
    ifB.we[p]            = 1'b0;
    ifB.addr[p*16 +: 16] = a;
    ifB.req[p]           = 1'b1;
  endtask

  task automatic expectA(input logic [3:0] a, input logic [15:0] d, input int c);
    sbA.push_back('{ack: a, rdata: d, cyc: c});
  endtask

  task automatic expectB(input logic [3:0] a, input logic [15:0] d, input int c);
    sbB.push_back('{ack: a, rdata: d, cyc: c});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    reset     = 1'b0;
    ifA.req   = '0;
    ifA.we    = '0;
    ifA.addr  = '0;
    ifA.wdata = '0;
    ifB.req   = '0;
    ifB.we    = '0;
    ifB.addr  = '0;
    ifB.wdata = '0;
    memA[10'h010] <= 16'hBEEF;
    memA[10'h020] <= 16'h5A5A;
    for (int i = 0; i < 4; i++) memB[10'h030 + i] <= 16'hA000 + 16'(i);
    tick();
    tick();

    checkOutput("reset mem_en", 32'(memEnA), 32'd0);
    checkOutput("reset mem_we", 32'(memWeA), 32'd0);
    checkOutput("reset mem_addr", 32'(memAddrA), 32'd0);
    checkOutput("reset mem_wdata", 32'(memWdataA), 32'd0);
    checkOutput("reset ack", 32'(ifA.ack), 32'd0);
    checkOutput("reset rdata", 32'(ifA.rdata), 32'd0);
    checkOutput("reset busy", 32'(ifA.busy), 32'd0);
    checkOutput("B reset busy", 32'(ifB.busy), 32'd0);
    reset = 1'b1;

    // Single load by PE0
    c = cycNum;
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
    expectA(4'b0001, 16'hBEEF, c + 2);
    tick();
    checkOutput("load mem_en", 32'(memEnA), 32'd1);
    checkOutput("load mem_addr", 32'(memAddrA), 32'h0010);
    checkOutput("load mem_we", 32'(memWeA), 32'd0);
    checkOutput("load busy", 32'(ifA.busy), 32'd1);
    tick();
    ifA.req = '0;
    checkOutput("ack-state mem_en", 32'(memEnA), 32'd0);
    tick();
    checkOutput("after ack busy", 32'(ifA.busy), 32'd0);
    checkOutput("idle rdata", 32'(ifA.rdata), 32'd0);

    // Store by PE1, inputs corrupted after latching, then PE0 reads it back
    c = cycNum;
    applyStimulus(1, 1'b1, 16'h0020, 16'h1234);
    expectA(4'b0010, 16'h5A5A, c + 2);
    tick();
    checkOutput("store mem_we", 32'(memWeA), 32'd1);
    checkOutput("store mem_wdata", 32'(memWdataA), 32'h1234);
    checkOutput("store mem_addr", 32'(memAddrA), 32'h0020);
    ifA.wdata[16 +: 16] = 16'hFFFF;
    ifA.addr[16 +: 16]  = 16'h0040;
    tick();
    checkOutput("latched mem_wdata", 32'(memWdataA), 32'h1234);
    checkOutput("latched mem_addr", 32'(memAddrA), 32'h0020);
    checkOutput("ack-state mem_we", 32'(memWeA), 32'd0);
    ifA.req = '0;
    ifA.we  = '0;
    tick();
    c = cycNum;
    applyStimulus(0, 1'b0, 16'h0020, 16'h0000);
    expectA(4'b0001, 16'h1234, c + 2);
    tick();
    tick();
    ifA.req = '0;
    tick();

    // Contention from reset, each requester drops after its own ack
    doReset();
    c = cycNum;
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1, 1'b0, 16'h0020, 16'h0000);
    expectA(4'b0001, 16'hBEEF, c + 2);
    expectA(4'b0010, 16'h1234, c + 5);
    repeat (6) begin
      tick();
      ifA.req = ifA.req & ~ifA.ack;
    end
`ifdef MEMARB_STATS_EN
    checkOutput("stall_cnt contention", 32'(stallCntA), 32'd4);
`endif

    // Contention with both requests held: strict alternation
    doReset();
    c = cycNum;
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1, 1'b0, 16'h0020, 16'h0000);
    expectA(4'b0001, 16'hBEEF, c + 2);
    expectA(4'b0010, 16'h1234, c + 5);
    expectA(4'b0001, 16'hBEEF, c + 8);
    expectA(4'b0010, 16'h1234, c + 11);
    repeat (11) tick();
    ifA.req = '0;
    tick();
    tick();

    // Reset during MEM: aborted grant gets no ack, ptr returns to 0
    doReset();
    c = cycNum;
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
    expectA(4'b0001, 16'hBEEF, c + 2);
    tick();
    tick();
    ifA.req = '0;
    tick();
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1, 1'b0, 16'h0020, 16'h0000);
    tick();
    checkOutput("rotated grant addr", 32'(memAddrA), 32'h0020);
    reset = 1'b0;
    tick();
    checkOutput("mid-op reset mem_en", 32'(memEnA), 32'd0);
    checkOutput("mid-op reset ack", 32'(ifA.ack), 32'd0);
    checkOutput("mid-op reset busy", 32'(ifA.busy), 32'd0);
    checkOutput("mid-op reset mem_addr", 32'(memAddrA), 32'd0);
    reset = 1'b1;
    c = cycNum;
    expectA(4'b0001, 16'hBEEF, c + 2);
    expectA(4'b0010, 16'h1234, c + 5);
    repeat (6) begin
      tick();
      ifA.req = ifA.req & ~ifA.ack;
    end

    // Four-PE pointer wrap: PE2 grant leaves ptr=3, then 4'b1010 serves PE3 then PE1
    c = cycNum;
    applyStimulusB(2, 16'h0032);
    expectB(4'b0100, 16'hA002, c + 2);
    tick();
    tick();
    ifB.req = '0;
    tick();
    c = cycNum;
    applyStimulusB(1, 16'h0031);
    applyStimulusB(3, 16'h0033);
    expectB(4'b1000, 16'hA003, c + 2);
    expectB(4'b0010, 16'hA001, c + 5);
    repeat (6) begin
      tick();
      ifB.req = ifB.req & ~ifB.ack;
    end
    c = cycNum;
    for (int i = 0; i < 4; i++) applyStimulusB(i, 16'h0030 + 16'(i));
    expectB(4'b0100, 16'hA002, c + 2);
    tick();
    tick();
    ifB.req = '0;
    tick();
    tick();

`ifdef MEMARB_STATS_EN
    // Long contention saturates the stall counter
    doReset();
    bypassA = 1'b1;
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1, 1'b0, 16'h0020, 16'h0000);
    repeat (70000) tick();
    checkOutput("stall_cnt saturate", 32'(stallCntA), 32'h0000FFFF);
    ifA.req = '0;
    repeat (4) tick();
    bypassA = 1'b0;
`endif

    checkOutput("A scoreboard drained", sbA.size(), 32'd0);
    checkOutput("B scoreboard drained", sbB.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
